cgra_cfg_loader: RTL and testbench

//  Byte-serial configuration front end of the mini AIE CGRA 2x2 top. It parses framed

---
 rtl/cgra_cfg_pkg.sv | 27 ++
 rtl/cgra_cfg_timeout.sv | 37 +++
 rtl/cgra_cfg_loader.sv | 164 ++++++++++++++++
 tb/tb_cgra_cfg_loader.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_cfg_pkg.sv
// Shared definitions for the CGRA byte-serial config path: frame states, header layout, widths.
// Used by the loader and by the tile-side config decode.
package cgra_cfg_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int TILE_W = 2;
    localparam int ADDR_W = 4;

    // HDR byte layout: {tile[7:6], rsvd[5:4], addr[3:0]}
    localparam int HDR_TILE_LSB = 6;
    localparam int HDR_RSVD_LSB = 4;
    localparam int HDR_RSVD_W   = 2;
    localparam int HDR_ADDR_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DLO,
        ST_DHI,
        ST_CHK
    } cfg_state_e;

    function automatic logic hdr_rsvd_ok(input logic [7:0] hdr);
        return hdr[HDR_RSVD_LSB +: HDR_RSVD_W] == '0;
    endfunction

endpackage

// File: rtl/cgra_cfg_timeout.sv
// Mid-frame idle watchdog: 8-bit saturating counter, expiry pulses on the TIMEOUT-th counted cycle.
// Zero latency to expire_o; clear wins over count, and expiry restarts the count from 0.
module cgra_cfg_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign expire_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expire_o) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cgra_cfg_loader.sv
// Parses SYNC/HDR/DLO/DHI/CHK byte frames and issues one-cycle tile config writes.
// Write strobe one cycle after CHK is accepted; no backpressure, bytes taken whenever din_valid && ena.
module cgra_cfg_loader
    import cgra_cfg_pkg::*;
#(
    parameter logic [7:0] SYNC    = SYNC_BYTE,
    parameter int         TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [7:0]        din,
    input  logic              din_valid,
    output logic              cfg_we,
    output logic [TILE_W-1:0] cfg_tile,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [15:0]       cfg_data,
    output logic              busy,
    output logic              err,
    output logic [7:0]        frame_cnt
);

    cfg_state_e        state_q, state_d;
    logic [TILE_W-1:0] tile_q, tile_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        dlo_q, dlo_d;
    logic [7:0]        dhi_q, dhi_d;
    logic [7:0]        chk_q, chk_d;
    logic              we_q, we_d;
    logic [TILE_W-1:0] cfg_tile_q, cfg_tile_d;
    logic [ADDR_W-1:0] cfg_addr_q, cfg_addr_d;
    logic [15:0]       cfg_data_q, cfg_data_d;
    logic              err_q, err_d;
    logic [7:0]        fcnt_q, fcnt_d;

    logic accept;
    logic busy_w;
    logic tmo_expire;

    assign accept = din_valid && ena;
    assign busy_w = (state_q != ST_IDLE);

    // Counter runs only while a frame is open and the design is enabled but starved.
    cgra_cfg_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (accept || !busy_w),
        .en_i     (busy_w && ena && !accept),
        .expire_o (tmo_expire)
    );

    always_comb begin
        state_d    = state_q;
        tile_d     = tile_q;
        addr_d     = addr_q;
        dlo_d      = dlo_q;
        dhi_d      = dhi_q;
        chk_d      = chk_q;
        we_d       = 1'b0;
        cfg_tile_d = cfg_tile_q;
        cfg_addr_d = cfg_addr_q;
        cfg_data_d = cfg_data_q;
        err_d      = err_q;
        fcnt_d     = fcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept && (din == SYNC)) begin
                    state_d = ST_HDR;
                    err_d   = 1'b0;
                end
            end
            ST_HDR: begin
                if (accept) begin
                    if (!hdr_rsvd_ok(din)) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        tile_d  = din[HDR_TILE_LSB +: TILE_W];
                        addr_d  = din[HDR_ADDR_LSB +: ADDR_W];
                        chk_d   = din;
                        state_d = ST_DLO;
                    end
                end
            end
            ST_DLO: begin
                if (accept) begin
                    dlo_d   = din;
                    chk_d   = chk_q ^ din;
                    state_d = ST_DHI;
                end
            end
            ST_DHI: begin
                if (accept) begin
                    dhi_d   = din;
                    chk_d   = chk_q ^ din;
                    state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (accept) begin
                    state_d = ST_IDLE;
                    if (din == chk_q) begin
                        we_d       = 1'b1;
                        cfg_tile_d = tile_q;
                        cfg_addr_d = addr_q;
                        cfg_data_d = {dhi_q, dlo_q};
                        fcnt_d     = fcnt_q + 8'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Expiry only fires on non-accepting cycles, so it never races a commit.
        if (tmo_expire) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tile_q     <= '0;
            addr_q     <= '0;
            dlo_q      <= '0;
            dhi_q      <= '0;
            chk_q      <= '0;
            we_q       <= 1'b0;
            cfg_tile_q <= '0;
            cfg_addr_q <= '0;
            cfg_data_q <= '0;
            err_q      <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            tile_q     <= tile_d;
            addr_q     <= addr_d;
            dlo_q      <= dlo_d;
            dhi_q      <= dhi_d;
            chk_q      <= chk_d;
            we_q       <= we_d;
            cfg_tile_q <= cfg_tile_d;
            cfg_addr_q <= cfg_addr_d;
            cfg_data_q <= cfg_data_d;
            err_q      <= err_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign cfg_we    = we_q;
    assign cfg_tile  = cfg_tile_q;
    assign cfg_addr  = cfg_addr_q;
    assign cfg_data  = cfg_data_q;
    assign busy      = busy_w;
    assign err       = err_q;
    assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_cgra_cfg_loader.sv
// Bench for cgra_cfg_loader: directed scenarios plus randomized byte streams against a frame-level model.
module tb_cgra_cfg_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        din_valid = 1'b0;
    logic        cfg_we;
    logic [1:0]  cfg_tile;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        busy;
    logic        err;
    logic [7:0]  frame_cnt;

    int vectors = 0;
    int miscompares = 0;

    cgra_cfg_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .din       (din),
        .din_valid (din_valid),
        .cfg_we    (cfg_we),
        .cfg_tile  (cfg_tile),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .busy      (busy),
        .err       (err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: bytes of the open frame are collected in a queue and judged whole.
    logic [7:0]  mq[$];
    int          m_idle = 0;
    logic        m_we = 0, m_err = 0;
    logic [1:0]  m_tile = 0;
    logic [3:0]  m_addr = 0;
    logic [15:0] m_data = 0;
    logic [7:0]  m_fcnt = 0;

    task automatic model_clock();
        logic [7:0] c;
        if (!rst_n) begin
            mq.delete();
            m_idle = 0; m_we = 0; m_err = 0; m_tile = 0; m_addr = 0; m_data = 0; m_fcnt = 0;
            return;
        end
        m_we = 0;
        if (ena && din_valid) begin
            m_idle = 0;
            if (mq.size() == 0) begin
                if (din == 8'hA5) begin
                    mq.push_back(din);
                    m_err = 0;
                end
            end else begin
                mq.push_back(din);
                if (mq.size() == 2 && din[5:4] != 2'b00) begin
                    m_err = 1;
                    mq.delete();
                end else if (mq.size() == 5) begin
                    c = mq[1] ^ mq[2] ^ mq[3];
                    if (mq[4] == c) begin
                        m_we = 1;
                        m_tile = mq[1][7:6];
                        m_addr = mq[1][3:0];
                        m_data = {mq[3], mq[2]};
                        m_fcnt = m_fcnt + 8'd1;
                    end else begin
                        m_err = 1;
                    end
                    mq.delete();
                end
            end
        end else if (ena && mq.size() > 0) begin
            m_idle++;
            if (m_idle >= 255) begin
                mq.delete();
                m_idle = 0;
                m_err = 1;
            end
        end
    endtask

    function automatic logic [32:0] dut_vec();
        return {cfg_we, cfg_tile, cfg_addr, cfg_data, busy, err, frame_cnt};
    endfunction

    function automatic logic [32:0] exp_vec();
        logic b;
        b = (mq.size() != 0);
        return {m_we, m_tile, m_addr, m_data, b, m_err, m_fcnt};
    endfunction

    task automatic step(input logic e, input logic v, input logic [7:0] d);
        ena = e; din_valid = v; din = d;
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
    endtask

    function automatic void make_frame(input logic [1:0] t, input logic [3:0] a, input logic [15:0] d,
                                       output logic [7:0] f [5]);
        f[0] = 8'hA5;
        f[1] = {t, 2'b00, a};
        f[2] = d[7:0];
        f[3] = d[15:8];
        f[4] = f[1] ^ f[2] ^ f[3];
    endfunction

    task automatic test_reset();
        do_reset();
        vectors++;
        if (dut_vec() !== 33'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", dut_vec());
        end
    endtask

    task automatic test_good_frame();
        logic [7:0] b [5];
        b = '{8'hA5, 8'h42, 8'h34, 8'h12, 8'h64};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, b[i]);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL good_frame byte%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if ({cfg_we, cfg_tile, cfg_addr, cfg_data, frame_cnt, err} !== {1'b1, 2'd1, 4'd2, 16'h1234, 8'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL good_frame_commit: got we=%b t=%0d a=%0d d=%h fc=%0d e=%b want 1 1 2 1234 1 0",
                     cfg_we, cfg_tile, cfg_addr, cfg_data, frame_cnt, err);
        end
        step(1'b1, 1'b0, 8'h00);
        vectors++;
        if (cfg_we !== 1'b0 || cfg_data !== 16'h1234) begin
            miscompares++;
            $display("FAIL good_frame_pulse: got we=%b d=%h want 0 1234", cfg_we, cfg_data);
        end
    endtask

    task automatic test_bad_chk();
        logic [7:0] b [11];
        b = '{8'hA5, 8'h42, 8'h34, 8'h12, 8'h65, 8'hA5, 8'h81, 8'hCD, 8'hAB, 8'h81 ^ 8'hCD ^ 8'hAB, 8'h00};
        for (int i = 0; i < 11; i++) begin
            step(1'b1, i != 10, b[i]);
            vectors++;
            if (dut_vec() !== exp_vec() || (i < 5 && cfg_we !== 1'b0)) begin
                miscompares++;
                $display("FAIL bad_chk step%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            if (i == 4 || i == 5) begin
                vectors++;
                if (err !== (i == 4)) begin
                    miscompares++;
                    $display("FAIL bad_chk_err step%0d: got %b want %b", i, err, i == 4);
                end
            end
        end
    endtask

    task automatic test_rsvd();
        step(1'b1, 1'b1, 8'hA5);
        step(1'b1, 1'b1, 8'h72);
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rsvd_abort: got err=%b busy=%b want 1 0", err, busy);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 8'h00);
            vectors++;
            if (dut_vec() !== exp_vec() || busy !== 1'b0 || cfg_we !== 1'b0) begin
                miscompares++;
                $display("FAIL rsvd_idle step%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] f [5];
        step(1'b1, 1'b1, 8'hA5);
        step(1'b1, 1'b1, 8'h42);
        for (int i = 0; i < 254; i++) step(1'b1, 1'b0, 8'h00);
        vectors++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_254: got busy=%b err=%b want 1 0", busy, err);
        end
        step(1'b1, 1'b0, 8'h00);
        vectors++;
        if (busy !== 1'b0 || err !== 1'b1 || cfg_we !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_255: got busy=%b err=%b we=%b want 0 1 0", busy, err, cfg_we);
        end
        make_frame(2'd3, 4'hB, 16'hBEEF, f);
        step(1'b1, 1'b1, f[0]);
        step(1'b1, 1'b1, f[1]);
        for (int i = 0; i < 1000; i++) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
        vectors++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL ena_freeze: got busy=%b err=%b want 1 0", busy, err);
        end
        for (int i = 2; i < 5; i++) step(1'b1, 1'b1, f[i]);
        vectors++;
        if (dut_vec() !== exp_vec() || cfg_we !== 1'b1 || cfg_data !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL ena_resume: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] f [5];
        int pulses[$];
        do_reset();
        for (int k = 0; k < 2; k++) begin
            make_frame(2'($urandom), 4'($urandom), 16'($urandom), f);
            for (int i = 0; i < 5; i++) begin
                step(1'b1, 1'b1, f[i]);
                if (cfg_we === 1'b1) pulses.push_back(k * 5 + i);
            end
        end
        step(1'b1, 1'b0, 8'h00);
        vectors++;
        if (pulses.size() != 2 || frame_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL b2b_count: got pulses=%0d fc=%0d want 2 2", pulses.size(), frame_cnt);
        end else begin
            vectors++;
            if (pulses[0] != 4 || pulses[1] != 9) begin
                miscompares++;
                $display("FAIL b2b_spacing: got %0d,%0d want 4,9", pulses[0], pulses[1]);
            end
        end
        step(1'b1, 1'b1, 8'hA5);
        step(1'b1, 1'b1, 8'h42);
        step(1'b1, 1'b1, 8'h34);
        rst_n = 1'b0;
        step(1'b1, 1'b1, 8'h12);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 8'h64);
        vectors++;
        if (dut_vec() !== 33'd0) begin
            miscompares++;
            $display("FAIL reset_midframe: got %h want 0", dut_vec());
        end
    endtask

    task automatic test_wrap();
        logic [7:0] f [5];
        do_reset();
        for (int k = 0; k < 256; k++) begin
            make_frame(2'($urandom), 4'($urandom), 16'($urandom), f);
            for (int n = $urandom_range(0, 2); n > 0; n--) begin
                logic [7:0] noise;
                noise = 8'($urandom);
                if (noise == 8'hA5) noise = 8'h5A;
                step(1'b1, 1'b1, noise);
            end
            for (int i = 0; i < 5; i++) begin
                while ($urandom_range(0, 5) == 0) step(1'($urandom_range(0, 1)), 1'b0, 8'($urandom));
                step(1'b1, 1'b1, f[i]);
                vectors++;
                if (dut_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL wrap frame%0d byte%0d: got %h want %h", k, i, dut_vec(), exp_vec());
                end
            end
        end
        vectors++;
        if (frame_cnt !== 8'd0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_final: got fc=%0d err=%b want 0 0", frame_cnt, err);
        end
    endtask

    task automatic test_random();
        logic [7:0] stream[$];
        logic [7:0] f [5];
        logic e, v;
        for (int k = 0; k < 120; k++) begin
            make_frame(2'($urandom), 4'($urandom), 16'($urandom), f);
            case ($urandom_range(0, 4))
                0: f[4] = f[4] ^ 8'(1 << $urandom_range(0, 7));
                1: f[1][5:4] = 2'($urandom_range(1, 3));
                2: f[3] = 8'($urandom);
                default: ;
            endcase
            for (int i = 0; i < 5; i++) stream.push_back(f[i]);
            if ($urandom_range(0, 3) == 0) stream.push_back(8'($urandom));
        end
        for (int c = 0; c < 2500 && stream.size() > 0; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                for (int i = 0; i < 260; i++) step(1'b1, 1'b0, 8'h00);
            end
            e = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 9) < 7);
            step(e, v, v ? stream[0] : 8'($urandom));
            if (e && v) void'(stream.pop_front());
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc%0d: got %h want %h", c, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_rsvd();
        test_timeout();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
